// File: rtl/fft_bitrev_reader_if.sv
// Signal bundle for the bit-reversed sample reader: control, RAM cache-read port and output stream.
// master = reader side, slave = the RAM/consumer side.
interface fft_bitrev_reader_if #(
  parameter int LOG2N  = 12,
  parameter int DATA_W = 16,
  parameter int OUT_W  = 32
) ();
  logic              start;
  logic              busy;
  logic              done;
  logic [11:0]       ram_rd_adr;
  logic              ram_rd_en;
  logic [DATA_W-1:0] ram_rd_data;
  logic [OUT_W-1:0]  m_data;
  logic [LOG2N-1:0]  m_idx;
  logic              m_valid;
  logic              m_ready;

  modport master (
    input  start,
    output busy,
    output done,
    output ram_rd_adr,
    output ram_rd_en,
    input  ram_rd_data,
    output m_data,
    output m_idx,
    output m_valid,
    input  m_ready
  );

  modport slave (
    output start,
    input  busy,
    input  done,
    input  ram_rd_adr,
    input  ram_rd_en,
    output ram_rd_data,
    input  m_data,
    input  m_idx,
    input  m_valid,
    output m_ready
  );
endinterface

// File: rtl/fft_bitrev_reader.sv
// Streams one frame of RAM samples in bit-reversed address order as {sample, 0} complex beats.
// First beat 2 cycles after RUN entry, 1 beat/cycle; reads throttled so in-flight + buffered never exceeds 2.
module fft_bitrev_reader #(
  parameter int LOG2N  = 12,
  parameter int DATA_W = 16,
  parameter int OUT_W  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  fft_bitrev_reader_if.master  bus
);

  localparam logic [LOG2N-1:0] LAST = '1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [LOG2N-1:0]  icnt;
  logic [LOG2N-1:0]  ocnt;
  logic              rd_q;
  logic [1:0]        occ;
  logic [1:0]        occ_nxt;
  logic [DATA_W-1:0] ent0;
  logic [DATA_W-1:0] ent1;
  logic [DATA_W-1:0] ent0_nxt;
  logic [DATA_W-1:0] ent1_nxt;
  logic [2:0]        pend;
  logic              issue;
  logic              xfer;
  logic              m_valid_i;
  logic              busy_i;
  logic              done_i;
  logic [11:0]       adr;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    for (int b = 0; b < LOG2N; b++) begin
      r[b] = v[LOG2N-1-b];
    end
    return r;
  endfunction

  assign m_valid_i = (occ != 2'd0);
  assign xfer      = m_valid_i & bus.m_ready;
  // A beat leaving this cycle frees its slot for a read issued in the same cycle.
  assign pend      = {2'b00, rd_q} + {1'b0, occ} - {2'b00, xfer};

  always_comb begin
    adr             = '0;
    adr[LOG2N-1:0]  = bitrev(icnt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    busy_i    = 1'b0;
    done_i    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy_i = 1'b1;
        issue  = (pend < 3'd2);
        if (issue && (icnt == LAST)) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        busy_i = 1'b1;
        if (xfer && (ocnt == LAST)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done_i    = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      icnt <= '0;
      ocnt <= '0;
      rd_q <= 1'b0;
    end else begin
      rd_q <= issue;
      if ((state == IDLE) && bus.start) begin
        icnt <= '0;
        ocnt <= '0;
      end else begin
        if (issue) begin
          icnt <= icnt + 1'b1;
        end
        if (xfer) begin
          ocnt <= ocnt + 1'b1;
        end
      end
    end
  end

  // Shift on transfer first, then drop the returning sample into the first free slot.
  always_comb begin
    ent0_nxt = ent0;
    ent1_nxt = ent1;
    occ_nxt  = occ;
    if (xfer) begin
      ent0_nxt = ent1;
      occ_nxt  = occ - 2'd1;
    end
    if (rd_q) begin
      if (occ_nxt == 2'd0) begin
        ent0_nxt = bus.ram_rd_data;
      end else begin
        ent1_nxt = bus.ram_rd_data;
      end
      occ_nxt = occ_nxt + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent0 <= '0;
      ent1 <= '0;
      occ  <= 2'd0;
    end else begin
      ent0 <= ent0_nxt;
      ent1 <= ent1_nxt;
      occ  <= occ_nxt;
    end
  end

  assign bus.busy       = busy_i;
  assign bus.done       = done_i;
  assign bus.ram_rd_en  = issue;
  assign bus.ram_rd_adr = adr;
  assign bus.m_valid    = m_valid_i;
  assign bus.m_idx      = ocnt;
  assign bus.m_data     = {ent0, {(OUT_W-DATA_W){1'b0}}};

endmodule

// File: tb/tb_fft_bitrev_reader.sv
// Scoreboarded bench: an 8-point and a 4096-point reader against a RAM returning adr+0x100.
module tb_fft_bitrev_reader;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] data;
    logic [11:0] idx;
  } beat_t;

  beat_t       q3[$];
  beat_t       q12[$];
  logic [11:0] aq3[$];
  logic [11:0] aq12[$];

  int br3[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  int issued3 = 0, xfered3 = 0, done3 = 0, st_cyc3 = 0, done_cyc3 = 0, first_cyc3 = 0, last_cyc3 = -10;
  int issued12 = 0, xfered12 = 0, done12 = 0, st_cyc12 = 0, done_cyc12 = 0, last_cyc12 = -10;
  bit          stall3 = 1'b0;
  logic [31:0] sd3;
  logic [2:0]  si3;
  bit          bp_mode = 1'b0;
  int          bp_ph = 0;
  bit          bp_pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  fft_bitrev_reader_if #(.LOG2N(3))  bus3 ();
  fft_bitrev_reader_if #(.LOG2N(12)) bus12 ();

  fft_bitrev_reader #(.LOG2N(3))  dut3  (.clk(clk), .rst(rst), .bus(bus3));
  fft_bitrev_reader #(.LOG2N(12)) dut12 (.clk(clk), .rst(rst), .bus(bus12));

  always @(posedge clk) if (bus3.ram_rd_en)  bus3.ram_rd_data  <= 16'h0100 + {4'h0, bus3.ram_rd_adr};
  always @(posedge clk) if (bus12.ram_rd_en) bus12.ram_rd_data <= 16'h0100 + {4'h0, bus12.ram_rd_adr};

  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] bitrev12(input logic [11:0] v);
    logic [11:0] r;
    for (int b = 0; b < 12; b++) r[11-b] = v[b];
    return r;
  endfunction

  task automatic push_frame3();
    beat_t b;
    logic [11:0] a;
    for (int n = 0; n < 8; n++) begin
      a = 12'(br3[n]);
      aq3.push_back(a);
      b.data = {16'h0100 + {4'h0, a}, 16'h0000};
      b.idx  = 12'(n);
      q3.push_back(b);
    end
  endtask

  task automatic push_frame12();
    beat_t b;
    logic [11:0] a;
    for (int n = 0; n < 4096; n++) begin
      a = bitrev12(12'(n));
      aq12.push_back(a);
      b.data = {16'h0100 + {4'h0, a}, 16'h0000};
      b.idx  = 12'(n);
      q12.push_back(b);
    end
  endtask

  task automatic start3(input bit now);
    if (!now) @(posedge clk);
    #1 bus3.start = 1'b1;
    st_cyc3 = cyc;
    @(posedge clk);
    #1 bus3.start = 1'b0;
  endtask

  task automatic start12();
    @(posedge clk);
    #1 bus12.start = 1'b1;
    st_cyc12 = cyc;
    @(posedge clk);
    #1 bus12.start = 1'b0;
  endtask

  task automatic wait_done3(input int target, input int budget);
    int k = 0;
    while (done3 < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    chk(done3 >= target, "done3_timeout", 64'(done3), 64'(target));
  endtask

  task automatic wait_done12(input int target, input int budget);
    int k = 0;
    while (done12 < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    chk(done12 >= target, "done12_timeout", 64'(done12), 64'(target));
  endtask

  // Monitor for the 8-point reader.
  always @(negedge clk) begin
    beat_t       e;
    logic [11:0] ea;
    if (rst) begin
      stall3  = 1'b0;
      issued3 = 0;
      xfered3 = 0;
    end else begin
      if (bus3.ram_rd_en) begin
        issued3++;
        if (aq3.size() == 0) chk(1'b0, "adr3_extra", 64'(bus3.ram_rd_adr), 64'hFFF);
        else begin
          ea = aq3.pop_front();
          chk(bus3.ram_rd_adr == ea, "adr3", 64'(bus3.ram_rd_adr), 64'(ea));
        end
      end
      if (stall3) chk(bus3.m_valid && bus3.m_data == sd3 && bus3.m_idx == si3, "hold3",
                      64'({bus3.m_valid, bus3.m_data, bus3.m_idx}), 64'({1'b1, sd3, si3}));
      if (bus3.m_valid && bus3.m_ready) begin
        xfered3++;
        if (q3.size() == 0) chk(1'b0, "beat3_extra", 64'(bus3.m_data), 64'h0);
        else begin
          e = q3.pop_front();
          chk(bus3.m_data == e.data, "data3", 64'(bus3.m_data), 64'(e.data));
          chk(12'(bus3.m_idx) == e.idx, "idx3", 64'(bus3.m_idx), 64'(e.idx));
        end
        if (bus3.m_idx == 3'd0) first_cyc3 = cyc;
        if (bus3.m_idx == 3'd7) last_cyc3 = cyc;
      end
      if (bus3.ram_rd_en) chk(issued3 - xfered3 <= 2, "outstanding3", 64'(issued3 - xfered3), 64'd2);
      stall3 = bus3.m_valid && !bus3.m_ready;
      sd3    = bus3.m_data;
      si3    = bus3.m_idx;
      if (bus3.done) begin
        done3++;
        done_cyc3 = cyc;
        chk(cyc == last_cyc3 + 1, "done3_lat", 64'(cyc - last_cyc3), 64'd1);
      end
    end
  end

  // Monitor for the 4096-point reader.
  always @(negedge clk) begin
    beat_t       e;
    logic [11:0] ea;
    if (!rst) begin
      if (bus12.ram_rd_en) begin
        if (issued12 == 17) chk(bus12.ram_rd_adr == 12'h880, "adr12_issue17", 64'(bus12.ram_rd_adr), 64'h880);
        issued12++;
        if (aq12.size() == 0) chk(1'b0, "adr12_extra", 64'(bus12.ram_rd_adr), 64'hFFF);
        else begin
          ea = aq12.pop_front();
          if (bus12.ram_rd_adr != ea) chk(1'b0, "adr12", 64'(bus12.ram_rd_adr), 64'(ea));
        end
      end
      if (bus12.m_valid && bus12.m_ready) begin
        xfered12++;
        if (q12.size() == 0) chk(1'b0, "beat12_extra", 64'(bus12.m_data), 64'h0);
        else begin
          e = q12.pop_front();
          chk(bus12.m_data == e.data && 12'(bus12.m_idx) == e.idx, "beat12",
              64'({bus12.m_data, bus12.m_idx}), 64'({e.data, e.idx}));
        end
        if (bus12.m_idx == 12'hFFF) last_cyc12 = cyc;
      end
      if (bus12.done) begin
        done12++;
        done_cyc12 = cyc;
        chk(cyc == last_cyc12 + 1, "done12_lat", 64'(cyc - last_cyc12), 64'd1);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) begin
        bus3.m_ready = bp_pat[bp_ph];
        bp_ph = (bp_ph + 1) % 4;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    int iss0;
    int x0;
    int busy_bad;
    bus3.start   = 1'b0;
    bus3.m_ready = 1'b0;
    bus12.start  = 1'b0;
    bus12.m_ready = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk(bus3.busy == 1'b0, "rst_busy", 64'(bus3.busy), 64'd0);
    chk(bus3.done == 1'b0, "rst_done", 64'(bus3.done), 64'd0);
    chk(bus3.m_valid == 1'b0, "rst_valid", 64'(bus3.m_valid), 64'd0);
    chk(bus3.ram_rd_en == 1'b0, "rst_rd_en", 64'(bus3.ram_rd_en), 64'd0);
    chk(bus3.ram_rd_adr == 12'h000, "rst_adr", 64'(bus3.ram_rd_adr), 64'd0);
    chk(bus3.m_data == 32'h0, "rst_data", 64'(bus3.m_data), 64'd0);
    chk(bus3.m_idx == 3'd0, "rst_idx", 64'(bus3.m_idx), 64'd0);
    chk(bus12.busy == 1'b0 && bus12.m_valid == 1'b0, "rst12", 64'({bus12.busy, bus12.m_valid}), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;

    // Natural-order delivery with the consumer always ready.
    bus3.m_ready = 1'b1;
    push_frame3();
    start3(1'b0);
    wait_done3(1, 40);
    chk(first_cyc3 - st_cyc3 == 3, "first_beat3", 64'(first_cyc3 - st_cyc3), 64'd3);
    chk(last_cyc3 - first_cyc3 == 7, "rate3", 64'(last_cyc3 - first_cyc3), 64'd7);
    chk(done_cyc3 - st_cyc3 == 11, "frame_time3", 64'(done_cyc3 - st_cyc3), 64'd11);
    chk(q3.size() == 0 && aq3.size() == 0, "drain3", 64'(q3.size() + aq3.size()), 64'd0);

    // Backpressure 1,0,0,1 pattern.
    x0 = xfered3;
    push_frame3();
    bp_ph = 0;
    bp_mode = 1'b1;
    start3(1'b0);
    wait_done3(2, 80);
    bp_mode = 1'b0;
    #2 bus3.m_ready = 1'b1;
    chk(xfered3 - x0 == 8, "bp_count", 64'(xfered3 - x0), 64'd8);
    chk(q3.size() == 0 && aq3.size() == 0, "bp_drain", 64'(q3.size() + aq3.size()), 64'd0);

    // Full 4096-point frame.
    bus12.m_ready = 1'b1;
    push_frame12();
    start12();
    wait_done12(1, 5000);
    chk(done_cyc12 - st_cyc12 == 4099, "frame_time12", 64'(done_cyc12 - st_cyc12), 64'd4099);
    chk(xfered12 == 4096, "beats12", 64'(xfered12), 64'd4096);
    chk(q12.size() == 0 && aq12.size() == 0, "drain12", 64'(q12.size() + aq12.size()), 64'd0);
    repeat (5) @(posedge clk);
    chk(done12 == 1, "single_done12", 64'(done12), 64'd1);

    // Second start during beat 3 must be ignored.
    push_frame3();
    iss0 = issued3;
    busy_bad = 0;
    start3(1'b0);
    for (int j = 1; j <= 10; j++) begin
      bus3.start = (j == 6);
      @(negedge clk);
      if (!bus3.busy) busy_bad++;
      @(posedge clk);
      #1;
    end
    bus3.start = 1'b0;
    wait_done3(3, 40);
    repeat (15) @(posedge clk);
    chk(busy_bad == 0, "busy_held", 64'(busy_bad), 64'd0);
    chk(done3 == 3, "ign_single_done", 64'(done3), 64'd3);
    chk(issued3 - iss0 == 8, "ign_no_refetch", 64'(issued3 - iss0), 64'd8);

    // Asynchronous reset during beat 5.
    push_frame3();
    start3(1'b0);
    repeat (7) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk(bus3.busy == 1'b0, "arst_busy", 64'(bus3.busy), 64'd0);
    chk(bus3.m_valid == 1'b0, "arst_valid", 64'(bus3.m_valid), 64'd0);
    chk(bus3.ram_rd_en == 1'b0, "arst_rd_en", 64'(bus3.ram_rd_en), 64'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    q3.delete();
    aq3.delete();
    d = done3;
    repeat (10) @(posedge clk);
    chk(done3 == d, "arst_no_done", 64'(done3), 64'(d));
    push_frame3();
    start3(1'b0);
    wait_done3(d + 1, 40);
    chk(first_cyc3 - st_cyc3 == 3, "arst_restart", 64'(first_cyc3 - st_cyc3), 64'd3);
    chk(q3.size() == 0 && aq3.size() == 0, "arst_drain", 64'(q3.size() + aq3.size()), 64'd0);

    // Back-to-back frames: second start in the cycle after done.
    d = done3;
    push_frame3();
    push_frame3();
    start3(1'b0);
    wait_done3(d + 1, 40);
    start3(1'b1);
    wait_done3(d + 2, 40);
    chk(done_cyc3 - st_cyc3 == 11, "b2b_time", 64'(done_cyc3 - st_cyc3), 64'd11);
    chk(q3.size() == 0 && aq3.size() == 0, "b2b_drain", 64'(q3.size() + aq3.size()), 64'd0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_bitrev_reader.md
Name: fft_bitrev_reader

Overview:
- Read-side engine for the FFT sample RAM. Fetches the 16-bit real samples loaded over AXI through the RAM's cache-read port (read address, registered data), in bit-reversed address order.
- Delivers them as 32-bit complex words on a valid/ready stream to the butterfly input cache.
- Runs one full frame per start pulse and never writes the RAM.

Parameters:
- LOG2N, 12, log2 of FFT length; N = 2**LOG2N; legal range 1..12.
- DATA_W, 16, width of one RAM sample.
- OUT_W, 32, complex output word width; must equal 2*DATA_W.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to read one frame.
- busy  output  1  high from the cycle after accepted start until done.
- done  output  1  one-cycle pulse after the last output beat is accepted.
- ram_rd_adr  output  12  RAM cache-read address; upper 12-LOG2N bits are 0.
- ram_rd_en  output  1  marks a cycle in which a read is issued.
- ram_rd_data  input  DATA_W  RAM read data, valid exactly 1 cycle after ram_rd_en.
- m_data  output  OUT_W  {sample, DATA_W'b0}: real part high, imaginary part zero.
- m_idx  output  LOG2N  natural-order index n of the beat.
- m_valid  output  1  beat valid.
- m_ready  input  1  downstream accepts; transfer = m_valid & m_ready.

Behaviour:
- Reset, asynchronous, effective immediately:
  - state=IDLE; busy, done, m_valid, ram_rd_en = 0.
  - ram_rd_adr = 0; m_data, m_idx = 0.
  - issue counter and output counter = 0; skid buffer emptied.
- Reset mid-frame abandons the frame with no done pulse. The first start after reset release begins a fresh frame at n=0.
- States:
  - IDLE: start=1 -> RUN. Counters cleared, busy=1 next cycle.
  - RUN: issues reads. After the read for n=N-1 is issued -> DRAIN.
  - DRAIN: no new reads. When the beat with m_idx=N-1 transfers -> DONE.
  - DONE: done=1 and busy=0 for one cycle -> IDLE.
  - start in any state other than IDLE is ignored.
- Address generation:
  - Issue counter i runs 0..N-1.
  - ram_rd_adr = bit-reverse of i over its LOG2N bits, zero-extended to 12 bits.
  - Counter increments only on cycles with ram_rd_en=1.
- Flow control:
  - 2-entry output buffer, with entry 0 driving m_*.
  - A read is issued only when (reads in flight + occupied entries) < 2, counting an entry freed by a transfer in the same cycle.
  - Returned data is written into the buffer on the cycle after ram_rd_en.
  - The buffer never overflows and no return data is dropped.
- Output rules:
  - Beats leave in natural order n = 0..N-1, with m_idx = n.
  - While m_valid=1 and m_ready=0, m_data and m_idx hold stable.
  - m_valid may rise without regard to m_ready.
- Throughput and latency:
  - With m_ready held high: 1 beat/cycle.
  - First m_valid appears 2 cycles after the RUN entry cycle (1 cycle to issue, 1 cycle RAM latency).
  - done comes 1 cycle after the last transfer.
  - Minimum frame time is N+3 cycles from start to done.
- Simultaneous events:
  - A transfer and a new return in the same cycle: entry 1 shifts to entry 0 and the return fills the freed slot.
  - start coinciding with the done cycle is ignored.
- Width rules:
  - m_data[OUT_W-1:DATA_W] = ram_rd_data as captured; m_data[DATA_W-1:0] = 0.
  - No sign extension or scaling.

Test Plan:
- Order check: LOG2N=3, RAM[a]=a+16'h100, m_ready=1, pulse start.
  - ram_rd_adr sequence must be 0,4,2,6,1,5,3,7.
  - m_data must be 32'h0100_0000, 32'h0104_0000, 32'h0102_0000, ... with m_idx 0..7 on consecutive cycles.
  - done must pulse 1 cycle after m_idx=7 transfers.
- Backpressure: LOG2N=3, m_ready toggling 1,0,0,1,...
  - No beat is lost or duplicated and m_data holds while stalled.
  - ram_rd_en must never leave more than 2 beats outstanding or buffered.
  - All 8 beats arrive in order.
- Full size: LOG2N=12, m_ready=1.
  - Issue 17 must read ram_rd_adr=12'h880 (bitrev of 12'h011).
  - Exactly 4096 beats, then a single done.
  - Start-to-done must be 4099 cycles.
- Ignored start: pulse start again at beat 3 of an LOG2N=3 frame.
  - Frame completes normally with one done.
  - busy stays 1 throughout and no second frame starts.
- Reset mid-frame: assert rst asynchronously between clock edges during beat 5.
  - busy, m_valid and ram_rd_en must drop immediately and no done may occur.
  - A subsequent start must begin at ram_rd_adr=0, m_idx=0.
- Back-to-back frames: issue start in the cycle after done.
  - The second frame must read the same address order.
  - The second frame must begin its m_idx count at 0.
